// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// FSM state encoding and operating-mode constants.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Gate-level full adder: two half-adder stages whose carries are ORed.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;
    logic g1;
    logic g2;

    xor u_x1 (p, a, b);
    and u_a1 (g1, a, b);
    xor u_x2 (sum, p, cin);
    and u_a2 (g2, p, cin);
    or  u_o1 (cout, g1, g2);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder, LSB-first, one bit per clock.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case
    assign res_nxt = WIDTH'({fa_sum, res_sr} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= (sub == SUB) ? ~b : b;
                        carry <= (sub == ADD) ? cin : 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum      <= res_nxt;
                        cout     <= fa_cout;
                        // carry still holds the carry into the MSB here
                        overflow <= carry ^ fa_cout;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start1, sub1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .sub      (sub8),
        .a        (a8),
        .b        (b8),
        .cin      (cin8),
        .busy     (busy8),
        .done     (done8),
        .sum      (sum8),
        .cout     (cout8),
        .overflow (ovf8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .sub      (sub1),
        .a        (a1),
        .b        (b1),
        .cin      (cin1),
        .busy     (busy1),
        .done     (done1),
        .sum      (sum1),
        .cout     (cout1),
        .overflow (ovf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow
    function automatic logic [65:0] model(input int w, input bit s,
                                          input longint ua_in, input longint ub_in,
                                          input bit ci);
        longint m, half, ua, ub, sa, sb, tot, st;
        bit c, o;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = ua_in & (m - 1);
        ub   = ub_in & (m - 1);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (!s) begin
            tot = ua + ub + longint'(ci);
            st  = sa + sb + longint'(ci);
            c   = (tot >= m);
        end else begin
            tot = ua - ub + m;
            st  = sa - sb;
            c   = (ua >= ub);
        end
        o = (st < -half) || (st > half - 1);
        return {o, c, 64'(tot % m)};
    endfunction

    task automatic drive(input bit wide, input bit st, input bit s,
                         input logic [7:0] av, input logic [7:0] bv, input bit ci);
        if (wide) begin
            start8 = st; sub8 = s; a8 = av; b8 = bv; cin8 = ci;
        end else begin
            start1 = st; sub1 = s; a1 = av[0]; b1 = bv[0]; cin1 = ci;
        end
    endtask

    task automatic run_op(input bit wide, input bit s, input logic [7:0] av,
                          input logic [7:0] bv, input bit ci, input int glitch,
                          input string tag);
        int w;
        int lat, ndone, nbusy, both;
        logic [65:0] exp;
        logic [7:0] rs;
        logic rc, ro;
        logic ob, od;
        w     = wide ? 8 : 1;
        lat   = -1;
        ndone = 0;
        nbusy = 0;
        both  = 0;
        rs    = '0;
        rc    = 1'b0;
        ro    = 1'b0;
        exp   = model(w, s, longint'(av), longint'(bv), ci);
        @(negedge clk);
        drive(wide, 1'b1, s, av, bv, ci);
        @(posedge clk);
        #1;
        drive(wide, 1'b0, ~s, ~av, ~bv, ~ci);
        ob = wide ? busy8 : busy1;
        od = wide ? done8 : done1;
        if (ob) nbusy++;
        if (ob && od) both++;
        for (int n = 1; n <= w + 6; n++) begin
            @(negedge clk);
            if (n == glitch)
                drive(wide, 1'b1, ~s, bv, av, ~ci);
            @(posedge clk);
            #1;
            drive(wide, 1'b0, s, av, bv, ci);
            ob = wide ? busy8 : busy1;
            od = wide ? done8 : done1;
            if (ob) nbusy++;
            if (ob && od) both++;
            if (od) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    rs  = wide ? sum8 : {7'b0, sum1};
                    rc  = wide ? cout8 : cout1;
                    ro  = wide ? ovf8 : ovf1;
                end
            end
        end
        chk({tag, ".latency"}, 64'(lat), 64'(w));
        chk({tag, ".done_count"}, 64'(ndone), 64'd1);
        chk({tag, ".busy_cycles"}, 64'(nbusy), 64'(w));
        chk({tag, ".busy_and_done"}, 64'(both), 64'd0);
        chk({tag, ".sum"}, 64'(rs), exp[63:0]);
        chk({tag, ".cout"}, 64'(rc), 64'(exp[64]));
        chk({tag, ".overflow"}, 64'(ro), 64'(exp[65]));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #2;
        chk("reset.busy", 64'(busy8), 64'd0);
        chk("reset.done", 64'(done8), 64'd0);
        chk("reset.sum", 64'(sum8), 64'd0);
        chk("reset.cout", 64'(cout8), 64'd0);
        chk("reset.overflow", 64'(ovf8), 64'd0);
        chk("reset.busy_w1", 64'(busy1), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b1, 1'b0, 8'h0F, 8'h01, 1'b0, 0, "add_0f_01");
        run_op(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
        run_op(1'b1, 1'b0, 8'h7F, 8'h00, 1'b1, 0, "add_7f_00_c1");
        run_op(1'b1, 1'b1, 8'h05, 8'h07, 1'b0, 0, "sub_05_07");
        run_op(1'b1, 1'b1, 8'h80, 8'h01, 1'b1, 0, "sub_80_01");
        run_op(1'b1, 1'b0, 8'h3C, 8'h5A, 1'b0, 3, "ignore_start");

        // Reset four cycles into an operation
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst.busy_before", 64'(busy8), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.busy", 64'(busy8), 64'd0);
        chk("midrst.done", 64'(done8), 64'd0);
        chk("midrst.sum", 64'(sum8), 64'd0);
        chk("midrst.cout", 64'(cout8), 64'd0);
        chk("midrst.overflow", 64'(ovf8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b1, 1'b0, 8'h12, 8'h34, 1'b1, 0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb;
            bit rsub, rci;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rsub = 1'($urandom_range(0, 1));
            rci  = 1'($urandom_range(0, 1));
            run_op(1'b1, rsub, ra, rb, rci, 0, $sformatf("rnd%0d", i));
        end

        for (int k = 0; k < 8; k++) begin
            logic [2:0] kv;
            kv = 3'(k);
            run_op(1'b0, 1'b0, {7'b0, kv[2]}, {7'b0, kv[1]}, kv[0], 0,
                   $sformatf("w1_add%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            logic [1:0] kv;
            kv = 2'(k);
            run_op(1'b0, 1'b1, {7'b0, kv[1]}, {7'b0, kv[0]}, 1'b0, 0,
                   $sformatf("w1_sub%0d", k));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
